// File: rtl/change_dispenser.sv
// Coin payout controller: pays a requested change amount greedily with 10c then 2c coins,
// tracking hopper inventory and reporting completion, shortfall and odd-cent residue.
module change_dispenser #(
    parameter int AMT_W  = 6,
    parameter int CNT_W  = 8,
    parameter int INIT10 = 0,
    parameter int INIT2  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             hopper_busy,
    output logic             coin10_out,
    output logic             coin2_out,
    input  logic             inv_load,
    input  logic [CNT_W-1:0] inv10_in,
    input  logic [CNT_W-1:0] inv2_in,
    output logic [CNT_W-1:0] stock10,
    output logic [CNT_W-1:0] stock2,
    output logic             done,
    output logic             short_err,
    output logic [AMT_W-1:0] residue
);

    typedef enum logic [1:0] {IDLE, PAY, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] INIT10_V = CNT_W'(INIT10);
    localparam logic [CNT_W-1:0] INIT2_V  = CNT_W'(INIT2);
    localparam logic [AMT_W-1:0] TEN      = AMT_W'(10);
    localparam logic [AMT_W-1:0] TWO      = AMT_W'(2);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] stock10_q, stock10_d;
    logic [CNT_W-1:0] stock2_q, stock2_d;
    logic             coin10_q, coin10_d;
    logic             coin2_q, coin2_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [AMT_W-1:0] residue_q, residue_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        stock10_d   = stock10_q;
        stock2_d    = stock2_q;
        coin10_d    = 1'b0;
        coin2_d     = 1'b0;
        done_d      = 1'b0;
        short_d     = short_q;
        residue_d   = residue_q;
        case (state_q)
            IDLE: begin
                // A load and a handshake in the same cycle both take effect.
                if (inv_load) begin
                    stock10_d = inv10_in;
                    stock2_d  = inv2_in;
                end
                if (req_valid) begin
                    remaining_d = req_amount;
                    state_d     = PAY;
                end
            end
            PAY: begin
                if (!hopper_busy) begin
                    if (remaining_q >= TEN && stock10_q != '0) begin
                        coin10_d    = 1'b1;
                        remaining_d = remaining_q - TEN;
                        stock10_d   = stock10_q - 1'b1;
                        state_d     = WAIT;
                    end else if (remaining_q >= TWO && stock2_q != '0) begin
                        coin2_d     = 1'b1;
                        remaining_d = remaining_q - TWO;
                        stock2_d    = stock2_q - 1'b1;
                        state_d     = WAIT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT: state_d = PAY;
            DONE: begin
                done_d    = 1'b1;
                residue_d = remaining_q;
                short_d   = (remaining_q >= TWO);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            stock10_q   <= INIT10_V;
            stock2_q    <= INIT2_V;
            coin10_q    <= 1'b0;
            coin2_q     <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            residue_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            stock10_q   <= stock10_d;
            stock2_q    <= stock2_d;
            coin10_q    <= coin10_d;
            coin2_q     <= coin2_d;
            done_q      <= done_d;
            short_q     <= short_d;
            residue_q   <= residue_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign coin10_out = coin10_q;
    assign coin2_out  = coin2_q;
    assign stock10    = stock10_q;
    assign stock2     = stock2_q;
    assign done       = done_q;
    assign short_err  = short_q;
    assign residue    = residue_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed vector table, randomized requests against a greedy
// payout model, and hand sequences for hopper stalls and reset mid-payout.
module tb_change_dispenser;

    localparam int AMT_W  = 6;
    localparam int CNT_W  = 8;
    localparam int INIT10 = 3;
    localparam int INIT2  = 4;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             hopper_busy;
    logic             coin10_out;
    logic             coin2_out;
    logic             inv_load;
    logic [CNT_W-1:0] inv10_in;
    logic [CNT_W-1:0] inv2_in;
    logic [CNT_W-1:0] stock10;
    logic [CNT_W-1:0] stock2;
    logic             done;
    logic             short_err;
    logic [AMT_W-1:0] residue;

    change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT10(INIT10), .INIT2(INIT2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready), .hopper_busy(hopper_busy), .coin10_out(coin10_out),
        .coin2_out(coin2_out), .inv_load(inv_load), .inv10_in(inv10_in), .inv2_in(inv2_in),
        .stock10(stock10), .stock2(stock2), .done(done), .short_err(short_err),
        .residue(residue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int s10; int s2; int amt;
        int n10; int n2; int res; int shrt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_inv(input int s10, input int s2);
        @(negedge clk);
        inv_load = 1'b1;
        inv10_in = CNT_W'(s10);
        inv2_in  = CNT_W'(s2);
        @(negedge clk);
        inv_load = 1'b0;
        chk("load_stock10", int'(stock10), s10);
        chk("load_stock2", int'(stock2), s2);
    endtask

    // Issue one request and observe the payout until done (bounded).
    task automatic run_req(input int amt, input bit rnd_busy,
                           output int n10, output int n2, output int res,
                           output int shrt, output int first_lat);
        int  cyc;
        bit  prev, got, order_ok, gap_ok, coin;
        n10 = 0; n2 = 0; res = -1; shrt = -1; first_lat = -1;
        prev = 1'b0; got = 1'b0; order_ok = 1'b1; gap_ok = 1'b1;
        @(negedge clk);
        chk("ready_before_req", int'(req_ready), 1);
        req_valid   = 1'b1;
        req_amount  = AMT_W'(amt);
        hopper_busy = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        for (int i = 0; i < 600; i++) begin
            hopper_busy = rnd_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            cyc++;
            coin = coin10_out | coin2_out;
            if (coin && prev) gap_ok = 1'b0;
            if (coin10_out && coin2_out) gap_ok = 1'b0;
            if (coin && first_lat < 0) first_lat = cyc;
            if (coin10_out) begin
                n10++;
                if (n2 > 0) order_ok = 1'b0;
            end
            if (coin2_out) n2++;
            prev = coin;
            if (done) begin
                res  = int'(residue);
                shrt = int'(short_err);
                got  = 1'b1;
                break;
            end
        end
        hopper_busy = 1'b0;
        chk("done_within_budget", int'(got), 1);
        chk("pulse_gap", int'(gap_ok), 1);
        chk("tens_before_twos", int'(order_ok), 1);
    endtask

    // Greedy reference: as many 10c as needed and stocked, then 2c from the rest.
    function automatic void model(input int s10, input int s2, input int amt,
                                  output int n10, output int n2, output int res,
                                  output int shrt);
        int rem;
        n10  = (amt / 10 < s10) ? amt / 10 : s10;
        rem  = amt - 10 * n10;
        n2   = (rem / 2 < s2) ? rem / 2 : s2;
        rem  = rem - 2 * n2;
        res  = rem;
        shrt = (rem >= 2) ? 1 : 0;
    endfunction

    initial begin
        int n10, n2, res, shrt, lat;
        int e10, e2, eres, eshrt;
        int s10, s2, amt;
        int pulses;
        bit seen;

        vecs[0] = '{5, 5, 16, 1, 3, 0, 0};
        vecs[1] = '{0, 9, 14, 0, 7, 0, 0};
        vecs[2] = '{5, 5, 7, 0, 3, 1, 0};
        vecs[3] = '{1, 0, 12, 1, 0, 2, 1};
        vecs[4] = '{5, 5, 0, 0, 0, 0, 0};
        vecs[5] = '{5, 5, 1, 0, 0, 1, 0};
        vecs[6] = '{9, 9, 63, 6, 1, 1, 0};
        vecs[7] = '{2, 3, 63, 2, 3, 37, 1};
        vecs[8] = '{0, 0, 5, 0, 0, 5, 1};

        rst = 1'b0; req_valid = 1'b0; req_amount = '0; hopper_busy = 1'b0;
        inv_load = 1'b0; inv10_in = '0; inv2_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_stock10", int'(stock10), INIT10);
        chk("rst_stock2", int'(stock2), INIT2);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_coins", int'(coin10_out) + int'(coin2_out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short_err), 0);
        chk("rst_residue", int'(residue), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_stock10", int'(stock10), INIT10);

        // Directed vectors
        for (int v = 0; v < 9; v++) begin
            load_inv(vecs[v].s10, vecs[v].s2);
            run_req(vecs[v].amt, 1'b0, n10, n2, res, shrt, lat);
            chk($sformatf("vec%0d_n10", v), n10, vecs[v].n10);
            chk($sformatf("vec%0d_n2", v), n2, vecs[v].n2);
            chk($sformatf("vec%0d_residue", v), res, vecs[v].res);
            chk($sformatf("vec%0d_short", v), shrt, vecs[v].shrt);
            chk($sformatf("vec%0d_stock10", v), int'(stock10), vecs[v].s10 - vecs[v].n10);
            chk($sformatf("vec%0d_stock2", v), int'(stock2), vecs[v].s2 - vecs[v].n2);
            if (vecs[v].n10 + vecs[v].n2 > 0)
                chk($sformatf("vec%0d_latency", v), lat, 2);
        end

        // Randomized requests against the greedy model
        for (int it = 0; it < 40; it++) begin
            s10 = int'($urandom_range(0, 6));
            s2  = int'($urandom_range(0, 20));
            amt = int'($urandom_range(0, 63));
            load_inv(s10, s2);
            model(s10, s2, amt, e10, e2, eres, eshrt);
            run_req(amt, it[0], n10, n2, res, shrt, lat);
            chk($sformatf("rnd%0d_n10", it), n10, e10);
            chk($sformatf("rnd%0d_n2", it), n2, e2);
            chk($sformatf("rnd%0d_residue", it), res, eres);
            chk($sformatf("rnd%0d_short", it), shrt, eshrt);
            chk($sformatf("rnd%0d_stock10", it), int'(stock10), s10 - e10);
            chk($sformatf("rnd%0d_stock2", it), int'(stock2), s2 - e2);
        end

        // Hopper stall in PAY with an inv_load attempt that must be ignored
        load_inv(5, 5);
        @(negedge clk);
        req_valid = 1'b1; req_amount = AMT_W'(20);
        @(negedge clk);
        req_valid = 1'b0; hopper_busy = 1'b1;
        inv_load = 1'b1; inv10_in = '0; inv2_in = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            inv_load = 1'b0;
            chk("busy_no_coin", int'(coin10_out) + int'(coin2_out), 0);
            chk("busy_not_ready", int'(req_ready), 0);
            chk("busy_stock10", int'(stock10), 5);
            chk("busy_stock2", int'(stock2), 5);
        end
        hopper_busy = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2 && !seen; c++) begin
            @(negedge clk);
            if (coin10_out) seen = 1'b1;
        end
        chk("resume_after_busy", int'(seen), 1);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk("busy_residue", int'(residue), 0);
                chk("busy_short", int'(short_err), 0);
            end
        end
        chk("busy_done_seen", int'(seen), 1);
        chk("busy_final_stock10", int'(stock10), 3);
        chk("busy_final_stock2", int'(stock2), 5);

        // Reset between the 2nd and 3rd coin of a 26c payout
        load_inv(5, 5);
        @(negedge clk);
        req_valid = 1'b1; req_amount = AMT_W'(26);
        @(negedge clk);
        req_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40 && pulses < 2; c++) begin
            @(negedge clk);
            if (coin10_out || coin2_out) pulses++;
        end
        chk("rstmid_two_pulses", pulses, 2);
        rst = 1'b0;
        #1;
        chk("rstmid_coins", int'(coin10_out) + int'(coin2_out), 0);
        chk("rstmid_done", int'(done), 0);
        chk("rstmid_ready", int'(req_ready), 1);
        chk("rstmid_stock10", int'(stock10), INIT10);
        chk("rstmid_stock2", int'(stock2), INIT2);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (coin10_out || coin2_out || done) pulses++;
            if (!req_ready) pulses++;
        end
        chk("rstmid_quiet_after", pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
